error_metric_acc: RTL and testbench

ERROR_METRIC_ACC -- requirements
Module: error_metric_acc

---
 rtl/error_metric_acc_if.sv | 32 +++
 rtl/error_metric_acc.sv | 104 ++++++++++
 tb/tb_error_metric_acc.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/error_metric_acc_if.sv
// Sample/result bundle for error_metric_acc; master drives samples, slave is the accumulator.
// With ERR_RATE_CNT_EN defined the bundle also carries o_err_cnt.
interface error_metric_acc_if #(
    parameter int W     = 16,
    parameter int CNT_W = 17,
    parameter int SUM_W = 33
);
    logic                i_start;
    logic                i_valid;
    logic                o_ready;
    logic signed [W-1:0] i_exact;
    logic signed [W-1:0] i_approx;
    logic                i_last;
    logic                o_done;
    logic [SUM_W-1:0]    o_sum_ed;
    logic [CNT_W-1:0]    o_count;
    logic signed [W-1:0] o_max_exact;
    logic [W:0]          o_max_ed;
`ifdef ERR_RATE_CNT_EN
    logic [CNT_W-1:0]    o_err_cnt;

    modport master (output i_start, i_valid, i_exact, i_approx, i_last,
                    input  o_ready, o_done, o_sum_ed, o_count, o_max_exact, o_max_ed, o_err_cnt);
    modport slave  (input  i_start, i_valid, i_exact, i_approx, i_last,
                    output o_ready, o_done, o_sum_ed, o_count, o_max_exact, o_max_ed, o_err_cnt);
`else
    modport master (output i_start, i_valid, i_exact, i_approx, i_last,
                    input  o_ready, o_done, o_sum_ed, o_count, o_max_exact, o_max_ed);
    modport slave  (input  i_start, i_valid, i_exact, i_approx, i_last,
                    output o_ready, o_done, o_sum_ed, o_count, o_max_exact, o_max_ed);
`endif
endinterface

// File: rtl/error_metric_acc.sv
// Error-distance accumulator comparing exact vs approximate multiplier products over a run.
// Optional ERR_RATE_CNT_EN adds a count of samples whose error distance is non-zero.
module error_metric_acc #(
    parameter int W     = 16,
    parameter int CNT_W = 17,
    parameter int SUM_W = 33
) (
    input logic               i_clk,
    input logic               i_rst_n,
    error_metric_acc_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

    state_t              state, state_nxt;
    logic                ready, done, acc;
    logic                s1_vld;
    logic signed [W:0]   s1_diff;
    logic signed [W-1:0] s1_exact;
    logic [W:0]          s1_abs;
    logic [SUM_W:0]      sum_add;
    logic [SUM_W-1:0]    sum_ed;
    logic [CNT_W-1:0]    count;
    logic signed [W-1:0] max_exact;
    logic [W:0]          max_ed;

    assign acc = bus.i_valid && ready && !bus.i_start;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.i_start) state_nxt = ACCUM;
        else begin
            case (state)
                ACCUM:   if (acc && bus.i_last) state_nxt = DRAIN;
                DRAIN:   state_nxt = DONE;
                default: state_nxt = state;
            endcase
        end
    end

    always_comb begin
        ready = (state == ACCUM);
        done  = (state == DONE);
    end

    // |diff| of a W+1-bit difference of two W-bit values always fits W+1 unsigned bits
    assign s1_abs  = s1_diff[W] ? $unsigned(-s1_diff) : $unsigned(s1_diff);
    assign sum_add = {1'b0, sum_ed} + {{(SUM_W-W){1'b0}}, s1_abs};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_vld    <= 1'b0;
            s1_diff   <= '0;
            s1_exact  <= '0;
            sum_ed    <= '0;
            count     <= '0;
            max_exact <= '0;
            max_ed    <= '0;
        end else if (bus.i_start) begin
            s1_vld    <= 1'b0;
            s1_diff   <= '0;
            s1_exact  <= '0;
            sum_ed    <= '0;
            count     <= '0;
            max_exact <= '0;
            max_ed    <= '0;
        end else begin
            s1_vld <= acc;
            if (acc) begin
                s1_diff  <= {bus.i_approx[W-1], bus.i_approx} - {bus.i_exact[W-1], bus.i_exact};
                s1_exact <= bus.i_exact;
            end
            if (s1_vld) begin
                sum_ed <= sum_add[SUM_W] ? '1 : sum_add[SUM_W-1:0];
                if (!(&count))           count     <= count + CNT_W'(1);
                if (s1_exact > max_exact) max_exact <= s1_exact;
                if (s1_abs > max_ed)      max_ed    <= s1_abs;
            end
        end
    end

`ifdef ERR_RATE_CNT_EN
    logic [CNT_W-1:0] err_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                                 err_cnt <= '0;
        else if (bus.i_start)                         err_cnt <= '0;
        else if (s1_vld && s1_diff != 0 && !(&err_cnt)) err_cnt <= err_cnt + CNT_W'(1);
    end

    assign bus.o_err_cnt = err_cnt;
`endif

    assign bus.o_ready     = ready;
    assign bus.o_done      = done;
    assign bus.o_sum_ed    = sum_ed;
    assign bus.o_count     = count;
    assign bus.o_max_exact = max_exact;
    assign bus.o_max_ed    = max_ed;
endmodule

// File: tb/tb_error_metric_acc.sv
// Self-checking bench for error_metric_acc: vector table, directed corner sequences,
// randomized runs against a plain-arithmetic model, and a full 8x8 multiplier sweep.
module tb_error_metric_acc;
    localparam int W = 16, CNT_W = 17, SUM_W = 33;

    typedef struct {
        logic signed [15:0] exact;
        logic signed [15:0] approx;
        logic               last;
        longint             sum;
        int                 cnt, mx, med, err;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    vec_t tbl[17];

    error_metric_acc_if #(.W(W), .CNT_W(CNT_W), .SUM_W(SUM_W)) bus();

    error_metric_acc #(.W(W), .CNT_W(CNT_W), .SUM_W(SUM_W)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_results(input string tag, input longint sum, input int cnt,
                               input int mx, input int med, input int err);
        chk({tag, "_sum"},  bus.o_sum_ed, sum);
        chk({tag, "_cnt"},  bus.o_count, cnt);
        chk({tag, "_mx"},   bus.o_max_exact, mx);
        chk({tag, "_med"},  bus.o_max_ed, med);
`ifdef ERR_RATE_CNT_EN
        chk({tag, "_err"},  bus.o_err_cnt, err);
`else
        if (err < 0) chk({tag, "_err"}, err, 0);
`endif
    endtask

    task automatic pulse_start();
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
    endtask

    task automatic drive(input int e, input int a, input logic l);
        bus.i_valid  = 1'b1;
        bus.i_exact  = 16'(e);
        bus.i_approx = 16'(a);
        bus.i_last   = l;
        tick();
        bus.i_valid  = 1'b0;
        bus.i_last   = 1'b0;
    endtask

    function automatic vec_t mk(int e, int a, logic l, longint s, int c, int mx, int med, int err);
        vec_t v;
        v.exact = 16'(e); v.approx = 16'(a); v.last = l;
        v.sum = s; v.cnt = c; v.mx = mx; v.med = med; v.err = err;
        return v;
    endfunction

    function automatic int iabs(int x);
        return (x < 0) ? -x : x;
    endfunction

    // Approximate multiplier under test in the sweep: product with low 4 bits truncated
    function automatic int approx_mul(int a, int b);
        return (a * b) & ~32'hF;
    endfunction

    initial begin
        logic   newrun;
        longint m_sum;
        int     m_cnt, m_mx, m_med, m_err, n, miss;

        bus.i_start = 0; bus.i_valid = 0; bus.i_last = 0;
        bus.i_exact = 0; bus.i_approx = 0;

        for (int i = 0; i < 9; i++) tbl[i] = mk(1234, 1234, 1'b0, 0, 0, 0, 0, 0);
        tbl[9]  = mk(1234, 1234, 1'b1, 0, 10, 1234, 0, 0);
        tbl[10] = mk(100, 90, 1'b0, 0, 0, 0, 0, 0);
        tbl[11] = mk(-50, -40, 1'b0, 0, 0, 0, 0, 0);
        tbl[12] = mk(200, 200, 1'b1, 20, 3, 200, 10, 2);
        tbl[13] = mk(-32768, 32767, 1'b1, 65535, 1, 0, 65535, 1);
        tbl[14] = mk(-5, -3, 1'b0, 0, 0, 0, 0, 0);
        tbl[15] = mk(300, -300, 1'b0, 0, 0, 0, 0, 0);
        tbl[16] = mk(-7, -7, 1'b1, 602, 3, 300, 600, 2);

        tick(); tick();
        chk("rst_ready", bus.o_ready, 0);
        chk("rst_done", bus.o_done, 0);
        chk_results("rst", 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        tick();

        // IDLE ignores samples
        drive(55, 99, 1'b1);
        tick();
        chk("idle_ready", bus.o_ready, 0);
        chk("idle_cnt", bus.o_count, 0);
        chk("idle_done", bus.o_done, 0);

        // vector table
        newrun = 1'b1;
        for (int i = 0; i < 17; i++) begin
            if (newrun) pulse_start();
            chk("tbl_ready", bus.o_ready, 1);
            drive(tbl[i].exact, tbl[i].approx, tbl[i].last);
            newrun = tbl[i].last;
            if (tbl[i].last) begin
                chk("tbl_done_early", bus.o_done, 0);
                tick();
                chk("tbl_done", bus.o_done, 1);
                chk_results($sformatf("tbl%0d", i), tbl[i].sum, tbl[i].cnt, tbl[i].mx,
                            tbl[i].med, tbl[i].err);
                drive(-1000, 1000, 1'b0);
                drive(7000, 1, 1'b1);
                tick();
                chk("hold_done", bus.o_done, 1);
                chk_results($sformatf("hold%0d", i), tbl[i].sum, tbl[i].cnt, tbl[i].mx,
                            tbl[i].med, tbl[i].err);
            end
        end

        // i_start collides with a valid sample after 5 of 8
        pulse_start();
        drive(10, 20, 1'b0); drive(-3, 9, 1'b0); drive(400, 0, 1'b0);
        drive(5, 5, 1'b0); drive(50, -70, 1'b0);
        bus.i_start = 1'b1;
        drive(1000, -1000, 1'b0);
        bus.i_start = 1'b0;
        tick();
        chk_results("restart_clr", 0, 0, 0, 0, 0);
        chk("restart_ready", bus.o_ready, 1);
        drive(7, 3, 1'b0);
        drive(-2, 4, 1'b1);
        tick();
        chk("restart_done", bus.o_done, 1);
        chk_results("restart", 10, 2, 7, 6, 2);

        // asynchronous reset mid-run
        pulse_start();
        drive(100, 110, 1'b0); drive(200, 190, 1'b0); drive(300, 300, 1'b0);
        tick();
        chk("prerst_cnt", bus.o_count, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ready", bus.o_ready, 0);
        chk("midrst_done", bus.o_done, 0);
        chk_results("midrst", 0, 0, 0, 0, 0);
        #1 rst_n = 1'b1;
        drive(11, 22, 1'b0); drive(33, 44, 1'b1);
        tick();
        chk("postrst_ready", bus.o_ready, 0);
        chk("postrst_done", bus.o_done, 0);
        chk_results("postrst", 0, 0, 0, 0, 0);

        // randomized runs against the arithmetic model
        for (int r = 0; r < 20; r++) begin
            pulse_start();
            n = $urandom_range(1, 40);
            m_sum = 0; m_cnt = 0; m_mx = 0; m_med = 0; m_err = 0;
            for (int k = 0; k < n; k++) begin
                logic signed [15:0] e, a;
                if ($urandom_range(0, 3) == 0) begin
                    bus.i_last = 1'b1;
                    tick();
                    bus.i_last = 1'b0;
                end
                e = 16'($urandom);
                a = ($urandom_range(0, 2) == 0) ? e : 16'($urandom);
                if ($urandom_range(0, 3) == 0) begin
                    e = 16'($signed(8'($urandom)));
                    a = e + 16'($urandom_range(0, 3));
                end
                drive(e, a, k == n - 1);
                m_sum += iabs(int'(a) - int'(e));
                m_cnt++;
                if (int'(e) > m_mx) m_mx = e;
                if (iabs(int'(a) - int'(e)) > m_med) m_med = iabs(int'(a) - int'(e));
                if (a != e) m_err++;
            end
            chk("rnd_done_early", bus.o_done, 0);
            tick();
            chk("rnd_done", bus.o_done, 1);
            chk_results($sformatf("rnd%0d", r), m_sum, m_cnt, m_mx, m_med, m_err);
        end

        // full 8x8 signed sweep, one sample per cycle
        pulse_start();
        m_sum = 0; m_cnt = 0; m_mx = 0; m_med = 0; m_err = 0; miss = 0;
        for (int a = -128; a < 128; a++) begin
            for (int b = -128; b < 128; b++) begin
                int p, q;
                p = a * b;
                q = approx_mul(a, b);
                if (!bus.o_ready) miss++;
                drive(p, q, (a == 127) && (b == 127));
                m_sum += iabs(q - p);
                m_cnt++;
                if (p > m_mx) m_mx = p;
                if (iabs(q - p) > m_med) m_med = iabs(q - p);
                if (q != p) m_err++;
            end
        end
        chk("sweep_ready_misses", miss, 0);
        tick();
        chk("sweep_done", bus.o_done, 1);
        chk_results("sweep", m_sum, m_cnt, m_mx, m_med, m_err);
        chk("sweep_cnt_65536", bus.o_count, 65536);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
